// File: rtl/spi_pkg.sv
// Shared definitions for the byte-wide SPI master: FSM encoding and byte geometry.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SCK_H = 2'd2,
        SCK_L = 2'd3
    } spi_state_t;

    localparam int SPI_BYTE_W   = 8;
    localparam int SPI_LAST_BIT = 7;
    localparam int SPI_CNT_W    = 3;

endpackage

// File: rtl/spi_clk_div.sv
// Phase timer for the SPI master: tick marks the last clk cycle of a CLK_DIV-long phase.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign tick = (cnt_reg == CNT_LAST);

    // A restart on state entry makes every phase exactly CLK_DIV cycles long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (restart || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 byte SPI master: MSB-first on mosi, miso captured just before each sck rise,
// ss_n only ever changes while sck is low so gated-clock slaves see no stray edge.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int N_SS    = 2,
    parameter int SEL_W   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic [SEL_W-1:0]      ss_sel,
    output logic                  busy,
    output logic                  done,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic [N_SS-1:0]       ss_n
);

    localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(SPI_LAST_BIT);

    spi_state_t state_reg, state_next;

    logic                  tick;
    logic                  restart;
    logic                  accept;
    logic                  rise;
    logic                  fall;
    logic                  finish;
    logic [SPI_BYTE_W-1:0] tx_sh_reg;
    logic [SPI_BYTE_W-1:0] rx_sh_reg;
    logic [SPI_CNT_W-1:0]  bit_cnt_reg;
    logic [N_SS-1:0]       ss_dec;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // An out-of-range index decodes to all-ones, so the transfer runs with no slave selected.
    for (genvar gi = 0; gi < N_SS; gi++) begin : g_ss_dec
        assign ss_dec[gi] = (int'(ss_sel) != gi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        rise       = 1'b0;
        fall       = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SETUP;
                    accept     = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_next = SCK_H;
                    rise       = 1'b1;
                end
            end
            SCK_H: begin
                if (tick) begin
                    state_next = SCK_L;
                    fall       = 1'b1;
                end
            end
            SCK_L: begin
                if (tick) begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = IDLE;
                        finish     = 1'b1;
                    end else begin
                        state_next = SCK_H;
                        rise       = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign restart = (state_next != state_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh_reg   <= '0;
            rx_sh_reg   <= '0;
            bit_cnt_reg <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rx_data     <= '0;
            sck         <= 1'b0;
            mosi        <= 1'b0;
            ss_n        <= '1;
        end else begin
            done <= 1'b0;
            if (accept) begin
                tx_sh_reg   <= tx_data;
                rx_sh_reg   <= '0;
                bit_cnt_reg <= '0;
                mosi        <= tx_data[SPI_BYTE_W-1];
                ss_n        <= ss_dec;
                busy        <= 1'b1;
            end
            if (rise) begin
                sck       <= 1'b1;
                rx_sh_reg <= {rx_sh_reg[SPI_BYTE_W-2:0], miso};
            end
            if (rise && (state_reg == SCK_L)) begin
                bit_cnt_reg <= bit_cnt_reg + SPI_CNT_W'(1);
            end
            // The last bit stays on mosi until the transfer closes.
            if (fall) begin
                sck <= 1'b0;
                if (bit_cnt_reg != LAST_BIT) begin
                    tx_sh_reg <= {tx_sh_reg[SPI_BYTE_W-2:0], 1'b0};
                    mosi      <= tx_sh_reg[SPI_BYTE_W-2];
                end
            end
            if (finish) begin
                ss_n    <= '1;
                busy    <= 1'b0;
                done    <= 1'b1;
                rx_data <= rx_sh_reg;
                mosi    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a CLK_DIV=2 build with a model gated-clock slave, and a CLK_DIV=1 build in mosi->miso loopback.
module tb_spi_master;

    localparam int WATCH_MAX = 200;

    typedef struct packed {
        logic [7:0] mosi;
        logic [7:0] rx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] tx0 = 8'h00, tx1 = 8'h00;
    logic [0:0] sel0 = 1'b0;
    logic [1:0] sel1 = 2'd0;
    logic       busy0, done0, sck0, mosi0, miso0;
    logic       busy1, done1, sck1, mosi1, miso1;
    logic [7:0] rx0, rx1;
    logic [1:0] ss_n0, ss_n1;

    spi_master #(.CLK_DIV(2), .N_SS(2), .SEL_W(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .tx_data(tx0), .ss_sel(sel0),
        .busy(busy0), .done(done0), .rx_data(rx0), .sck(sck0), .mosi(mosi0),
        .miso(miso0), .ss_n(ss_n0)
    );

    spi_master #(.CLK_DIV(1), .N_SS(2), .SEL_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx1), .ss_sel(sel1),
        .busy(busy1), .done(done1), .rx_data(rx1), .sck(sck1), .mosi(mosi1),
        .miso(miso1), .ss_n(ss_n1)
    );

    assign miso1 = mosi1;

    // Model counter-style slave on ss_n0[0], clocked by (!ss_n & sck).
    logic       g0;
    logic       sl_gprev = 1'b0;
    logic [7:0] sl_tx = 8'h00, sl_rx = 8'h00, sl_ctrl = 8'h00, sl_reply = 8'h00;
    int         sl_bits = 0;
    assign g0    = ~ss_n0[0] & sck0;
    assign miso0 = ss_n0[0] ? 1'b0 : sl_tx[7];

    always @(negedge ss_n0[0] or posedge g0 or negedge g0) begin
        if (g0) begin
            sl_rx = {sl_rx[6:0], mosi0};
            sl_bits++;
            if (sl_bits == 8) sl_ctrl = sl_rx;
        end else if (sl_gprev) begin
            sl_tx = {sl_tx[6:0], 1'b0};
        end else begin
            sl_tx   = sl_reply;
            sl_bits = 0;
        end
        sl_gprev = g0;
    end

    // Whole-run watch: ss_n must never change while sck is high on either build.
    logic [1:0] m_ss0 = 2'b11, m_ss1 = 2'b11;
    logic       m_sck0 = 1'b0, m_sck1 = 1'b0, m_rst = 1'b0;
    int         mon_viol = 0, mon_events = 0;
    always @(negedge clk) begin
        if (rst_n && m_rst) begin
            if (ss_n0 != m_ss0) begin
                mon_events++;
                if (sck0 || m_sck0) mon_viol++;
            end
            if (ss_n1 != m_ss1) begin
                mon_events++;
                if (sck1 || m_sck1) mon_viol++;
            end
        end
        m_ss0  = ss_n0;
        m_ss1  = ss_n1;
        m_sck0 = sck0;
        m_sck1 = sck1;
        m_rst  = rst_n;
    end

    task automatic kick(input int which, input logic [7:0] tx, input logic [1:0] sel, input bit hold);
        @(negedge clk);
        if (which == 0) begin
            start0 = 1'b1; tx0 = tx; sel0 = sel[0];
        end else begin
            start1 = 1'b1; tx1 = tx; sel1 = sel;
        end
        @(negedge clk);
        if (!hold) begin
            start0 = 1'b0;
            start1 = 1'b0;
        end
    endtask

    // Samples one transfer from cycle 1 (first negedge after acceptance) until done.
    task automatic watch(input int which, input logic [1:0] pat, input int poke_cyc,
                         output int done_at, output int pat_cnt, output int sel_cnt,
                         output int rises, output int high_cnt, output int toggles,
                         output logic [7:0] bits);
        logic       s, s_prev, d, m;
        logic [1:0] sn;
        done_at = -1; pat_cnt = 0; sel_cnt = 0; rises = 0; high_cnt = 0; toggles = 0;
        bits = 8'h00; s_prev = 1'b0;
        for (int c = 1; c <= WATCH_MAX && done_at < 0; c++) begin
            if (which == 0) begin
                s = sck0; d = done0; m = mosi0; sn = ss_n0;
            end else begin
                s = sck1; d = done1; m = mosi1; sn = ss_n1;
            end
            if (sn == pat) pat_cnt++;
            if (sn != 2'b11) sel_cnt++;
            if (s) high_cnt++;
            if (c > 1 && s != s_prev) toggles++;
            if (s && !s_prev) begin
                rises++;
                bits = {bits[6:0], m};
            end
            s_prev = s;
            if (poke_cyc > 0 && c == poke_cyc) begin
                start0 = 1'b1; tx0 = 8'hFF; sel0 = 1'b1;
            end
            if (poke_cyc > 0 && c == poke_cyc + 1) start0 = 1'b0;
            if (d) done_at = c;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({sck0, mosi0, busy0, done0} !== 4'b0000) begin
            $display("FAIL reset_ctl0 got sck/mosi/busy/done=%b want 0000", {sck0, mosi0, busy0, done0}); errors++;
        end
        checks++;
        if (ss_n0 !== 2'b11 || rx0 !== 8'h00) begin
            $display("FAIL reset_data0 got ss_n=%b rx=%h want 11/00", ss_n0, rx0); errors++;
        end
        checks++;
        if ({sck1, mosi1, busy1, done1} !== 4'b0000 || ss_n1 !== 2'b11 || rx1 !== 8'h00) begin
            $display("FAIL reset_dut1 got ctl=%b ss_n=%b rx=%h want 0000/11/00",
                     {sck1, mosi1, busy1, done1}, ss_n1, rx1); errors++;
        end
    endtask

    task automatic test_basic();
        int done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles;
        logic [7:0] bits;
        exp_t e;
        sl_reply = 8'h3C;
        exp_q.push_back('{mosi: 8'hA5, rx: 8'h3C});
        kick(0, 8'hA5, 2'd0, 1'b0);
        checks++;
        if (busy0 !== 1'b1 || sck0 !== 1'b0 || mosi0 !== 1'b1) begin
            $display("FAIL basic_setup got busy=%b sck=%b mosi=%b want 1/0/1", busy0, sck0, mosi0); errors++;
        end
        watch(0, 2'b10, 0, done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles, bits);
        e = exp_q.pop_front();
        checks++;
        if (done_at != 35) begin $display("FAIL basic_done_at got %0d want 35", done_at); errors++; end
        checks++;
        if (bits !== e.mosi) begin $display("FAIL basic_mosi got %h want %h", bits, e.mosi); errors++; end
        checks++;
        if (rx0 !== e.rx) begin $display("FAIL basic_rx got %h want %h", rx0, e.rx); errors++; end
        checks++;
        if (pat_cnt != 34 || sel_cnt != 34) begin
            $display("FAIL basic_ss_low got %0d/%0d want 34/34", pat_cnt, sel_cnt); errors++;
        end
        checks++;
        if (rises != 8 || high_cnt != 16 || toggles != 16) begin
            $display("FAIL basic_sck got rises=%0d high=%0d toggles=%0d want 8/16/16", rises, high_cnt, toggles); errors++;
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0 || mosi0 !== 1'b0) begin
            $display("FAIL basic_after got done=%b busy=%b mosi=%b want 0/0/0", done0, busy0, mosi0); errors++;
        end
        $display("xfer basic tx=a5 rx=%h done_at=%0d", rx0, done_at);
    endtask

    task automatic test_counter_slave();
        int done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles;
        logic [7:0] bits;
        exp_t e;
        sl_reply = 8'hA0;
        exp_q.push_back('{mosi: 8'h03, rx: 8'hA0});
        kick(0, 8'h03, 2'd0, 1'b0);
        watch(0, 2'b10, 0, done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles, bits);
        e = exp_q.pop_front();
        checks++;
        if (sl_ctrl !== e.mosi) begin $display("FAIL slave_ctrl got %h want %h", sl_ctrl, e.mosi); errors++; end
        checks++;
        if (rx0 !== e.rx || done_at != 35) begin
            $display("FAIL slave_rx got %h at %0d want %h at 35", rx0, done_at, e.rx); errors++;
        end
        $display("xfer slave tx=03 ctrl=%h rx=%h", sl_ctrl, rx0);
    endtask

    task automatic test_ignore_start();
        int done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles, extra;
        logic [7:0] bits;
        exp_t e;
        sl_reply = 8'hC3;
        exp_q.push_back('{mosi: 8'h5A, rx: 8'hC3});
        kick(0, 8'h5A, 2'd0, 1'b0);
        watch(0, 2'b10, 10, done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles, bits);
        e = exp_q.pop_front();
        checks++;
        if (bits !== e.mosi) begin $display("FAIL ignore_mosi got %h want %h", bits, e.mosi); errors++; end
        checks++;
        if (rx0 !== e.rx) begin $display("FAIL ignore_rx got %h want %h", rx0, e.rx); errors++; end
        checks++;
        if (pat_cnt != 34 || done_at != 35) begin
            $display("FAIL ignore_ss got low=%0d done_at=%0d want 34/35", pat_cnt, done_at); errors++;
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done0) extra++;
        end
        checks++;
        if (extra != 0) begin $display("FAIL ignore_one_done got extra=%0d want 0", extra); errors++; end
        tx0 = 8'h00; sel0 = 1'b0;
        $display("xfer ignore tx=5a rx=%h extra_done=%0d", rx0, extra);
    endtask

    task automatic test_back_to_back();
        int done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles;
        logic [7:0] bits;
        exp_t e;
        sl_reply = 8'h11;
        exp_q.push_back('{mosi: 8'h81, rx: 8'h11});
        exp_q.push_back('{mosi: 8'h7E, rx: 8'hEE});
        kick(0, 8'h81, 2'd0, 1'b1);
        tx0 = 8'h7E;
        watch(0, 2'b10, 0, done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles, bits);
        e = exp_q.pop_front();
        checks++;
        if (bits !== e.mosi || rx0 !== e.rx || done_at != 35) begin
            $display("FAIL b2b_first got mosi=%h rx=%h at %0d want %h/%h at 35", bits, rx0, done_at, e.mosi, e.rx); errors++;
        end
        checks++;
        if (ss_n0 !== 2'b11) begin $display("FAIL b2b_gap got ss_n=%b want 11", ss_n0); errors++; end
        sl_reply = 8'hEE;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if (ss_n0 !== 2'b10 || busy0 !== 1'b1) begin
            $display("FAIL b2b_restart got ss_n=%b busy=%b want 10/1", ss_n0, busy0); errors++;
        end
        watch(0, 2'b10, 0, done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles, bits);
        e = exp_q.pop_front();
        checks++;
        if (bits !== e.mosi || rx0 !== e.rx) begin
            $display("FAIL b2b_second got mosi=%h rx=%h want %h/%h", bits, rx0, e.mosi, e.rx); errors++;
        end
        checks++;
        if (pat_cnt != 34 || done_at != 35) begin
            $display("FAIL b2b_second_time got low=%0d done_at=%0d want 34/35", pat_cnt, done_at); errors++;
        end
        $display("xfer b2b second tx=7e rx=%h", rx0);
    endtask

    task automatic test_reset_mid();
        int done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles, n_rise, n_done;
        logic [7:0] bits;
        logic prev;
        exp_t e;
        sl_reply = 8'h69;
        kick(0, 8'h96, 2'd0, 1'b0);
        n_rise = 0; prev = 1'b0;
        for (int c = 0; c < WATCH_MAX && n_rise < 5; c++) begin
            if (sck0 && !prev) n_rise++;
            prev = sck0;
            if (n_rise < 5) @(negedge clk);
        end
        checks++;
        if (n_rise != 5 || sck0 !== 1'b1) begin
            $display("FAIL rstmid_reach got rises=%0d sck=%b want 5/1", n_rise, sck0); errors++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sck0 !== 1'b0 || ss_n0 !== 2'b11 || busy0 !== 1'b0 || rx0 !== 8'h00) begin
            $display("FAIL rstmid_immediate got sck=%b ss_n=%b busy=%b rx=%h want 0/11/0/00", sck0, ss_n0, busy0, rx0); errors++;
        end
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0) n_done++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done0) n_done++;
        end
        checks++;
        if (n_done != 0) begin $display("FAIL rstmid_no_done got %0d want 0", n_done); errors++; end
        sl_reply = 8'h5A;
        exp_q.push_back('{mosi: 8'hC3, rx: 8'h5A});
        kick(0, 8'hC3, 2'd0, 1'b0);
        watch(0, 2'b10, 0, done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles, bits);
        e = exp_q.pop_front();
        checks++;
        if (bits !== e.mosi || rx0 !== e.rx || sl_ctrl !== e.mosi || done_at != 35) begin
            $display("FAIL rstmid_next got mosi=%h rx=%h ctrl=%h at %0d want %h/%h/%h at 35",
                     bits, rx0, sl_ctrl, done_at, e.mosi, e.rx, e.mosi); errors++;
        end
        $display("xfer after_reset tx=c3 rx=%h", rx0);
    endtask

    task automatic test_div1();
        int done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles;
        logic [7:0] bits;
        exp_t e;
        exp_q.push_back('{mosi: 8'h01, rx: 8'h01});
        kick(1, 8'h01, 2'd1, 1'b0);
        watch(1, 2'b01, 0, done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles, bits);
        e = exp_q.pop_front();
        checks++;
        if (done_at != 18) begin $display("FAIL div1_done_at got %0d want 18", done_at); errors++; end
        checks++;
        if (pat_cnt != 17 || sel_cnt != 17) begin
            $display("FAIL div1_ss got %0d/%0d want 17/17", pat_cnt, sel_cnt); errors++;
        end
        checks++;
        if (toggles != 16 || rises != 8 || high_cnt != 8) begin
            $display("FAIL div1_sck got toggles=%0d rises=%0d high=%0d want 16/8/8", toggles, rises, high_cnt); errors++;
        end
        checks++;
        if (bits !== e.mosi || rx1 !== e.rx) begin
            $display("FAIL div1_data got mosi=%h rx=%h want %h/%h", bits, rx1, e.mosi, e.rx); errors++;
        end
        $display("xfer div1 tx=01 rx=%h done_at=%0d", rx1, done_at);
    endtask

    task automatic test_out_of_range();
        int done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles;
        logic [7:0] bits;
        exp_t e;
        exp_q.push_back('{mosi: 8'hC6, rx: 8'hC6});
        kick(1, 8'hC6, 2'd2, 1'b0);
        watch(1, 2'b11, 0, done_at, pat_cnt, sel_cnt, rises, high_cnt, toggles, bits);
        e = exp_q.pop_front();
        checks++;
        if (sel_cnt != 0) begin $display("FAIL oor_ss got %0d selected cycles want 0", sel_cnt); errors++; end
        checks++;
        if (done_at != 18) begin $display("FAIL oor_done got %0d want 18", done_at); errors++; end
        checks++;
        if (bits !== e.mosi || rx1 !== e.rx) begin
            $display("FAIL oor_data got mosi=%h rx=%h want %h/%h", bits, rx1, e.mosi, e.rx); errors++;
        end
        $display("xfer out_of_range tx=c6 rx=%h", rx1);
    endtask

    task automatic test_final();
        checks++;
        if (mon_viol != 0 || mon_events < 10) begin
            $display("FAIL ss_vs_sck got violations=%0d events=%0d want 0/>=10", mon_viol, mon_events); errors++;
        end
        checks++;
        if (exp_q.size() != 0) begin $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); errors++; end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_counter_slave();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_div1();
        test_out_of_range();
        test_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
